add_round_key_collect: RTL and testbench
========================================

# add_round_key_collect

Downstream neighbour of the column-wise MixColumns stage in the AES-128 round datapath. Accepts one 32-bit mixed column per handshake, collects four columns into a 128-bit state and XORs it with the current round key (AddRoundKey). The result is presented on a registered valid/ready output port to the next round's SubBytes input.

## Interface

- Parameters: none. All widths are fixed by AES-128.
- `clk` in 1: single clock. All logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `col_valid` in 1: `col_data` is valid.
- `col_ready` out 1: block can accept a column this cycle.
- `col_data` in 32: one mixed column.
  - `[7:0]` = row 0, `[15:8]` = row 1, `[23:16]` = row 2, `[31:24]` = row 3.
  - Columns arrive in order 0, 1, 2, 3.
- `rk_data` in 128: round key, column c at `[32c+31:32c]` with the same byte order. Must be stable in the cycle column 3 is accepted.
- `flush` in 1: discards a partially collected state.
- `state_valid` out 1: `state_data` holds a completed state.
- `state_ready` in 1: downstream accepts `state_data`.
- `state_data` out 128: MixColumns result XOR round key, column c at `[32c+31:32c]`.
- `col_idx` out 2: index of the next column expected (0–3).

## Operation

- Column handshake: `col_valid && col_ready`. Output handshake: `state_valid && state_ready`.
- Collect counter `col_idx`:
  - Increments on each column handshake and wraps 3 → 0.
  - Columns 0–2 are stored in internal buffers `buf0`..`buf2`.
- `col_ready` = `(col_idx != 3) || !state_valid || state_ready`.
  - Columns 0–2 are always accepted, even while the output is stalled.
  - Column 3 is accepted only when the output register is empty or drains in the same cycle.
  - `col_ready` has a combinational path from `state_ready`. This is intentional.
- On the column-3 handshake:
  - `state_data` <= {`col_data` ^ `rk[127:96]`, `buf2` ^ `rk[95:64]`, `buf1` ^ `rk[63:32]`, `buf0` ^ `rk[31:0]`}.
  - `state_valid` <= 1.
  - `col_idx` <= 0.
- `state_valid` clears on an output handshake, unless a column-3 handshake occurs in the same cycle. In that case it stays 1 and `state_data` takes the new value.
- `flush`:
  - Sets `col_idx` to 0. Buffer contents become don't-care.
  - Does not touch `state_valid` or `state_data`.
  - `flush` has priority over a simultaneous column handshake: the column is consumed (`col_ready` still reflects the rule above) but discarded, and `col_idx` ends at 0.
  - On a column-3 handshake with `flush`, no state is produced.
- Reset (`rst`=1 at a clock edge), regardless of any in-flight handshake:
  - `col_idx` = 0, `state_valid` = 0, `state_data` = 128'h0, `buf0`..`buf2` = 0.
  - `rst` overrides `flush` and all handshakes.
- Arithmetic is a pure bitwise XOR. No carries and no width growth.

## Timing

- Latency: `state_valid` is 1 in the cycle after the column-3 handshake.
- Throughput: one state per 4 cycles with `col_valid` and `state_ready` held high. No bubbles.
- `state_data` and `state_valid` are registered outputs. `state_data` holds stable while `state_valid && !state_ready`.
- `col_ready` depends only on the registered `col_idx`, the registered `state_valid` and `state_ready`.
- Stall depth: while the output is stalled, up to 3 further columns are absorbed. Column 3 of the next state waits with `col_ready`=0.

## Test plan

- FIPS-197 Appendix B round 1.
  - Stimulus: `rk_data` = 128'h05766c2a_3939a323_b12c5488_17fefaa0; columns 32'he5816604, 32'h9a19cbe0, 32'h7ad3f848, 32'h4c260628 on consecutive cycles; `state_ready`=1.
  - Required: `state_valid`=1 exactly one cycle after column 3, `state_data` = 128'h49506a02_43ea5b6b_2b359f68_f27f9ca4.
- Back-to-back with constant ready.
  - Stimulus: 3 states (12 columns) streamed with `col_valid`=1.
  - Required: `col_ready` stays 1 throughout, and `state_valid` pulses every 4th cycle with correct data.
- Backpressure.
  - Stimulus: `state_ready`=0 after the first state completes, while columns keep arriving.
  - Required: columns 0–2 of state 2 are accepted; `col_ready`=0 at `col_idx`=3; `state_data` is unchanged.
  - Then raise `state_ready` for one cycle: state 1 drains and column 3 of state 2 is accepted in the same cycle; `state_valid` stays 1 with the new data.
- Flush.
  - Stimulus: 2 columns, then `flush`=1, then 4 fresh columns (all-zero `rk_data`).
  - Required: `col_idx` = 0 after the flush, and the output equals exactly the 4 fresh columns.
  - Also required: `flush` coinciding with column 3 produces no `state_valid`.
- Reset mid-operation.
  - Stimulus: assert `rst` at `col_idx`=2, and separately while `state_valid`=1 and stalled.
  - Required: next cycle `col_idx`=0, `state_valid`=0, `state_data`=0; a subsequent clean 4-column sequence gives the correct result.

Source files
------------

// File: rtl/add_round_key_collect_if.sv
`default_nettype none
// ============================================================================
//  Module   : add_round_key_collect_if
//  Brief    : Column input / state output bundle for the AddRoundKey collector
//  Revision : 1.0  initial release
// ============================================================================
interface add_round_key_collect_if;
    logic         col_valid;
    logic         col_ready;
    logic [31:0]  col_data;
    logic [127:0] rk_data;
    logic         flush;
    logic         state_valid;
    logic         state_ready;
    logic [127:0] state_data;
    logic [1:0]   col_idx;

    modport master (
        output col_valid, col_data, rk_data, flush, state_ready,
        input  col_ready, state_valid, state_data, col_idx
    );

    modport slave (
        input  col_valid, col_data, rk_data, flush, state_ready,
        output col_ready, state_valid, state_data, col_idx
    );
endinterface
`default_nettype wire

// File: rtl/add_round_key_collect.sv
`default_nettype none
// ============================================================================
//  Module   : add_round_key_collect
//  Brief    : Collects four MixColumns outputs into an AES-128 state and
//             applies AddRoundKey behind a registered valid/ready port
//  Revision : 1.0  initial release
// ============================================================================
module add_round_key_collect (
    input  wire logic               clk,
    input  wire logic               rst,
    add_round_key_collect_if.slave  bus
);

    localparam logic [1:0] c_last_col = 2'd3;

    logic [1:0]   r_col_idx;
    logic [31:0]  r_buf0;
    logic [31:0]  r_buf1;
    logic [31:0]  r_buf2;
    logic         r_state_valid;
    logic [127:0] r_state_data;

    logic         w_col_ready;
    logic         w_col_hs;
    logic         w_out_hs;
    logic         w_produce;
    logic [127:0] w_next_state;

    // Column 3 may only land when the output slot is free or draining now.
    assign w_col_ready = (r_col_idx != c_last_col) || !r_state_valid || bus.state_ready;
    assign w_col_hs    = bus.col_valid && w_col_ready;
    assign w_out_hs    = r_state_valid && bus.state_ready;
    assign w_produce   = w_col_hs && !bus.flush && (r_col_idx == c_last_col);

    assign w_next_state = {bus.col_data ^ bus.rk_data[127:96],
                           r_buf2       ^ bus.rk_data[95:64],
                           r_buf1       ^ bus.rk_data[63:32],
                           r_buf0       ^ bus.rk_data[31:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_col_idx     <= 2'd0;
            r_buf0        <= 32'h0;
            r_buf1        <= 32'h0;
            r_buf2        <= 32'h0;
            r_state_valid <= 1'b0;
            r_state_data  <= 128'h0;
        end else begin
            if (bus.flush) begin
                r_col_idx <= 2'd0;
            end else if (w_col_hs) begin
                r_col_idx <= r_col_idx + 2'd1;
                case (r_col_idx)
                    2'd0:    r_buf0 <= bus.col_data;
                    2'd1:    r_buf1 <= bus.col_data;
                    2'd2:    r_buf2 <= bus.col_data;
                    default: ;
                endcase
            end

            // A new state wins over a same-cycle drain.
            if (w_produce) begin
                r_state_valid <= 1'b1;
                r_state_data  <= w_next_state;
            end else if (w_out_hs) begin
                r_state_valid <= 1'b0;
            end
        end
    end

    assign bus.col_ready   = w_col_ready;
    assign bus.state_valid = r_state_valid;
    assign bus.state_data  = r_state_data;
    assign bus.col_idx     = r_col_idx;

endmodule
`default_nettype wire

// File: tb/tb_add_round_key_collect.sv
`default_nettype none
// ============================================================================
//  Module   : tb_add_round_key_collect
//  Brief    : Directed and randomized bench for add_round_key_collect
//  Revision : 1.0  initial release
// ============================================================================
module tb_add_round_key_collect;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    add_round_key_collect_if bus ();

    add_round_key_collect dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: column list, output slot
    int           m_idx;
    logic [31:0]  m_cols [4];
    logic         m_valid;
    logic [127:0] m_data;
    bit           m_known = 1'b0;
    logic [127:0] cur_rk;

    function automatic logic [127:0] ark(input logic [31:0] c0, input logic [31:0] c1,
                                         input logic [31:0] c2, input logic [31:0] c3,
                                         input logic [127:0] k);
        logic [31:0]  cols [4];
        logic [127:0] r;
        cols[0] = c0; cols[1] = c1; cols[2] = c2; cols[3] = c3;
        r = '0;
        for (int i = 0; i < 4; i++) r[32*i +: 32] = cols[i] ^ k[32*i +: 32];
        return r;
    endfunction

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive, check combinational ready, clock, update model, check outputs.
    task automatic cyc(input logic v, input logic [31:0] d, input logic sr,
                       input logic fl, input logic rs);
        logic exp_rdy;
        logic hs;
        logic ohs;
        bus.col_valid   = v;
        bus.col_data    = d;
        bus.state_ready = sr;
        bus.flush       = fl;
        bus.rk_data     = cur_rk;
        rst             = rs;
        #1;
        exp_rdy = (m_idx != 3) || !m_valid || sr;
        if (m_known) chk("col_ready", {127'b0, bus.col_ready}, {127'b0, exp_rdy});
        hs  = v && exp_rdy;
        ohs = m_valid && sr;
        @(posedge clk);
        #1;
        if (rs) begin
            m_idx   = 0;
            m_valid = 1'b0;
            m_data  = '0;
            m_known = 1'b1;
        end else begin
            if (hs && !fl) m_cols[m_idx] = d;
            if (hs && !fl && m_idx == 3) begin
                m_data  = ark(m_cols[0], m_cols[1], m_cols[2], m_cols[3], cur_rk);
                m_valid = 1'b1;
            end else if (ohs) begin
                m_valid = 1'b0;
            end
            if (fl)      m_idx = 0;
            else if (hs) m_idx = (m_idx + 1) % 4;
        end
        if (m_known) begin
            chk("state_valid", {127'b0, bus.state_valid}, {127'b0, m_valid});
            chk("state_data",  bus.state_data, m_data);
            chk("col_idx",     {126'b0, bus.col_idx}, 128'(m_idx));
        end
        @(negedge clk);
    endtask

    task automatic send(input logic [31:0] d, input logic sr);
        cyc(1'b1, d, sr, 1'b0, 1'b0);
    endtask

    task automatic idle(input logic sr);
        cyc(1'b0, $urandom, sr, 1'b0, 1'b0);
    endtask

    initial begin
        logic [31:0]  c [4];
        logic [127:0] s_a;

        m_idx = 0; m_valid = 1'b0; m_data = '0;
        cur_rk = '0;

        // Reset
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("reset_valid", {127'b0, bus.state_valid}, 128'h0);
        chk("reset_data",  bus.state_data, 128'h0);
        chk("reset_idx",   {126'b0, bus.col_idx}, 128'h0);

        // FIPS-197 Appendix B round 1
        cur_rk = 128'h05766c2a_3939a323_b12c5488_17fefaa0;
        send(32'he5816604, 1'b1);
        send(32'h9a19cbe0, 1'b1);
        send(32'h7ad3f848, 1'b1);
        send(32'h4c260628, 1'b1);
        chk("fips_valid", {127'b0, bus.state_valid}, 128'h1);
        chk("fips_data",  bus.state_data, 128'h49506a02_43ea5b6b_2b359f68_f27f9ca4);
        idle(1'b1);

        // Back-to-back, three states
        for (int s = 0; s < 3; s++) begin
            cur_rk = {$urandom, $urandom, $urandom, $urandom};
            for (int i = 0; i < 4; i++) send($urandom, 1'b1);
        end
        idle(1'b1);

        // Backpressure
        cur_rk = {$urandom, $urandom, $urandom, $urandom};
        for (int i = 0; i < 4; i++) c[i] = $urandom;
        for (int i = 0; i < 4; i++) send(c[i], 1'b1);
        s_a = ark(c[0], c[1], c[2], c[3], cur_rk);
        for (int i = 0; i < 4; i++) c[i] = $urandom;
        send(c[0], 1'b0);
        send(c[1], 1'b0);
        send(c[2], 1'b0);
        send(c[3], 1'b0);
        send(c[3], 1'b0);
        chk("bp_idx",  {126'b0, bus.col_idx}, 128'd3);
        chk("bp_hold", bus.state_data, s_a);
        send(c[3], 1'b1);
        chk("bp_new_valid", {127'b0, bus.state_valid}, 128'h1);
        chk("bp_new_data",  bus.state_data, ark(c[0], c[1], c[2], c[3], cur_rk));
        idle(1'b0);
        idle(1'b1);

        // Flush mid-state, then fresh columns with zero key
        cur_rk = '0;
        send($urandom, 1'b1);
        send($urandom, 1'b1);
        cyc(1'b0, 32'h0, 1'b1, 1'b1, 1'b0);
        chk("flush_idx", {126'b0, bus.col_idx}, 128'h0);
        for (int i = 0; i < 4; i++) c[i] = $urandom;
        for (int i = 0; i < 4; i++) send(c[i], 1'b1);
        chk("flush_data", bus.state_data, {c[3], c[2], c[1], c[0]});
        idle(1'b1);

        // Flush coinciding with column 3
        for (int i = 0; i < 3; i++) send($urandom, 1'b1);
        cyc(1'b1, $urandom, 1'b1, 1'b1, 1'b0);
        chk("flush_c3_valid", {127'b0, bus.state_valid}, 128'h0);
        chk("flush_c3_idx",   {126'b0, bus.col_idx}, 128'h0);

        // Reset at col_idx 2 with a column in flight
        cur_rk = {$urandom, $urandom, $urandom, $urandom};
        send($urandom, 1'b1);
        send($urandom, 1'b1);
        cyc(1'b1, $urandom, 1'b1, 1'b0, 1'b1);
        chk("rst_mid_idx", {126'b0, bus.col_idx}, 128'h0);
        for (int i = 0; i < 4; i++) c[i] = $urandom;
        for (int i = 0; i < 4; i++) send(c[i], 1'b1);
        chk("rst_mid_after", bus.state_data, ark(c[0], c[1], c[2], c[3], cur_rk));

        // Reset while output stalled
        for (int i = 0; i < 4; i++) send($urandom, 1'b0);
        idle(1'b0);
        cyc(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);
        chk("rst_stall_valid", {127'b0, bus.state_valid}, 128'h0);
        chk("rst_stall_data",  bus.state_data, 128'h0);
        for (int i = 0; i < 4; i++) c[i] = $urandom;
        for (int i = 0; i < 4; i++) send(c[i], 1'b1);
        chk("rst_stall_after", bus.state_data, ark(c[0], c[1], c[2], c[3], cur_rk));

        // Randomized traffic
        for (int n = 0; n < 400; n++) begin
            if ($urandom % 4 == 0) cur_rk = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom % 4) != 0, $urandom, ($urandom % 3) != 0,
                ($urandom % 16) == 0, ($urandom % 64) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
